// File: rtl/bp_counter_dump_pkg.sv
// Shared types and constants for the counter-bank dump reader.
package bp_counter_dump_pkg;

    typedef enum logic [1:0] {
        e_idle,
        e_header,
        e_stream,
        e_done
    } state_e;

    localparam logic [7:0] header_magic_gp = 8'hBC;

    typedef struct packed {
        logic [7:0]  magic;
        logic [7:0]  hartid;
        logic [15:0] count;
    } header_s;

    function automatic header_s make_header(input logic [7:0] hartid, input logic [15:0] count);
        header_s h;
        h.magic  = header_magic_gp;
        h.hartid = hartid;
        h.count  = count;
        return h;
    endfunction

endpackage

// File: rtl/bp_counter_dump_cnt.sv
// Up counter with synchronous clear; clear takes priority but still adds up_i.
module bsg_counter_clear_up #(
    parameter int unsigned max_val_p = 1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic up_i,
    output logic [((max_val_p > 0) ? $clog2(max_val_p + 1) : 1)-1:0] count_o
);

    localparam int unsigned ptr_width_lp = (max_val_p > 0) ? $clog2(max_val_p + 1) : 1;

    logic [ptr_width_lp-1:0] count_q, count_d;

    always_comb begin
        count_d = clear_i ? '0 : count_q;
        count_d = count_d + ptr_width_lp'(up_i);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bp_counter_dump_mux.sv
// Word-granular selector over a flat vector; out-of-range selects return zero.
module bsg_mux #(
    parameter int unsigned width_p = 32,
    parameter int unsigned els_p   = 2
) (
    input  logic [els_p*width_p-1:0]                      data_i,
    input  logic [((els_p > 1) ? $clog2(els_p) : 1)-1:0]  sel_i,
    output logic [width_p-1:0]                            data_o
);

    int unsigned base;

    always_comb begin
        base   = 32'(sel_i) * width_p;
        data_o = '0;
        if (32'(sel_i) < els_p) begin
            data_o = data_i[base +: width_p];
        end
    end

endmodule

// File: rtl/bp_counter_dump.sv
// Snapshots the counter bank on request and streams header + counter words
// over a valid/ready-and link, optionally pulsing a clear at the end.
module bp_counter_dump
    import bp_counter_dump_pkg::*;
#(
    parameter int unsigned num_counters_p = 22,
    parameter int unsigned cnt_width_p    = 64,
    parameter int unsigned out_width_p    = 32,
    parameter int unsigned hartid_width_p = 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [hartid_width_p-1:0]            mhartid_i,
    input  logic [num_counters_p*cnt_width_p-1:0] counters_i,
    input  logic                                 snapshot_v_i,
    input  logic                                 clear_after_i,
    output logic [out_width_p-1:0]               data_o,
    output logic                                 v_o,
    input  logic                                 ready_and_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 clear_o
);

    localparam int unsigned words_per_cnt_lp = cnt_width_p / out_width_p;
    localparam int unsigned payload_words_lp = num_counters_p * words_per_cnt_lp;
    localparam int unsigned wid_w_lp = (words_per_cnt_lp > 1) ? $clog2(words_per_cnt_lp) : 1;
    localparam int unsigned cid_w_lp = (num_counters_p > 1) ? $clog2(num_counters_p) : 1;
    localparam int unsigned sel_w_lp = (payload_words_lp > 1) ? $clog2(payload_words_lp) : 1;

    state_e state_q, state_d;

    logic [num_counters_p*cnt_width_p-1:0] snap_q;
    logic [hartid_width_p-1:0]             hartid_q;
    logic                                  clear_q;

    logic [wid_w_lp-1:0]    widx;
    logic [cid_w_lp-1:0]    cidx;
    logic [sel_w_lp-1:0]    sel;
    logic [out_width_p-1:0] word_sel;
    header_s                header;

    logic capture, stream_xfer, word_last, cnt_last;

    assign capture     = (state_q == e_idle) & snapshot_v_i;
    assign stream_xfer = (state_q == e_stream) & ready_and_i;
    assign word_last   = (widx == wid_w_lp'(words_per_cnt_lp - 1));
    assign cnt_last    = (cidx == cid_w_lp'(num_counters_p - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            snap_q   <= '0;
            hartid_q <= '0;
            clear_q  <= 1'b0;
        end else if (capture) begin
            snap_q   <= counters_i;
            hartid_q <= mhartid_i;
            clear_q  <= clear_after_i;
        end
    end

    // Word index wraps to 0 via clear on the last word of each counter.
    bsg_counter_clear_up #(
        .max_val_p(words_per_cnt_lp - 1)
    ) word_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(capture | (stream_xfer & word_last)),
        .up_i   (stream_xfer & ~word_last),
        .count_o(widx)
    );

    bsg_counter_clear_up #(
        .max_val_p(num_counters_p - 1)
    ) ctr_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(capture),
        .up_i   (stream_xfer & word_last & ~cnt_last),
        .count_o(cidx)
    );

    // Linear word position; equals {cidx, widx} when words per counter is a power of two.
    assign sel = sel_w_lp'(32'(cidx) * words_per_cnt_lp + 32'(widx));

    bsg_mux #(
        .width_p(out_width_p),
        .els_p  (payload_words_lp)
    ) word_mux (
        .data_i(snap_q),
        .sel_i (sel),
        .data_o(word_sel)
    );

    assign header = make_header(8'(hartid_q), 16'(num_counters_p));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            e_idle:   if (snapshot_v_i) state_d = e_header;
            e_header: if (ready_and_i)  state_d = e_stream;
            e_stream: if (ready_and_i & word_last & cnt_last) state_d = e_done;
            e_done:   state_d = e_idle;
            default:  state_d = e_idle;
        endcase
    end

    always_comb begin
        v_o     = 1'b0;
        busy_o  = (state_q != e_idle);
        done_o  = 1'b0;
        clear_o = 1'b0;
        data_o  = '0;
        case (state_q)
            e_header: begin
                v_o    = 1'b1;
                data_o = out_width_p'(header);
            end
            e_stream: begin
                v_o    = 1'b1;
                data_o = word_sel;
            end
            e_done: begin
                done_o  = 1'b1;
                clear_o = clear_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bp_counter_dump.sv
// Randomized scoreboard bench for bp_counter_dump against a word-list reference model.
module tb_bp_counter_dump;

    localparam int unsigned NC = 22;
    localparam int unsigned CW = 64;
    localparam int unsigned OW = 32;
    localparam int unsigned HW = 8;
    localparam int unsigned W  = CW / OW;
    localparam int unsigned NWORDS = NC * W;

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic [HW-1:0]     mhartid_i = '0;
    logic [NC*CW-1:0]  counters_i;
    logic              snapshot_v_i = 1'b0;
    logic              clear_after_i = 1'b0;
    logic [OW-1:0]     data_o;
    logic              v_o;
    logic              ready_and_i = 1'b1;
    logic              busy_o, done_o, clear_o;

    logic [CW-1:0] cnt_a [NC];

    int vec = 0;
    int err = 0;

    // reference model state
    logic [OW-1:0] exp_q[$];
    int  m_rem = 0;        // words still to be transferred in the current dump
    bit  m_done = 0;       // dump finished, completion cycle pending
    bit  m_clr = 0;
    bit  m_post_rst = 0;
    int  m_accepts = 0;
    bit  started = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NC; k++) counters_i[k*CW +: CW] = cnt_a[k];
    end

    bp_counter_dump #(
        .num_counters_p(NC),
        .cnt_width_p   (CW),
        .out_width_p   (OW),
        .hartid_width_p(HW)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .mhartid_i    (mhartid_i),
        .counters_i   (counters_i),
        .snapshot_v_i (snapshot_v_i),
        .clear_after_i(clear_after_i),
        .data_o       (data_o),
        .v_o          (v_o),
        .ready_and_i  (ready_and_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .clear_o      (clear_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: sees the same inputs the DUT samples at the next rising edge.
    always @(negedge clk) begin
        if (started) begin
            chk("v_o",     {63'b0, v_o},     {63'b0, (m_rem > 0)});
            chk("busy_o",  {63'b0, busy_o},  {63'b0, (m_rem > 0) || m_done});
            chk("done_o",  {63'b0, done_o},  {63'b0, m_done});
            chk("clear_o", {63'b0, clear_o}, {63'b0, m_done && m_clr});
            if (m_done) chk("words_left_at_done", 64'(exp_q.size()), 64'd0);
            if (m_post_rst) chk("data_o_reset", 64'(data_o), 64'd0);
        end
        if (reset_i) begin
            m_rem = 0;
            m_done = 0;
            m_post_rst = 1;
            exp_q.delete();
        end else begin
            m_post_rst = 0;
            if (m_done) begin
                m_done = 0;
            end else if (m_rem > 0) begin
                if (ready_and_i) begin
                    m_rem--;
                    if (m_rem == 0) m_done = 1;
                end
            end else if (snapshot_v_i) begin
                logic [CW-1:0] c;
                exp_q.push_back({8'hBC, 8'(mhartid_i), 16'(NC)});
                for (int k = 0; k < NC; k++) begin
                    c = cnt_a[k];
                    for (int w = 0; w < W; w++) exp_q.push_back(c[w*OW +: OW]);
                end
                m_rem = NWORDS + 1;
                m_clr = clear_after_i;
                m_accepts++;
            end
        end
    end

    // Monitor: pops an expected word on every transfer, peeks during stalls.
    always @(negedge clk) begin
        if (started && !reset_i && v_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 64'(data_o), 64'hDEAD_0000_0000_0000);
            end else if (ready_and_i) begin
                chk("data_o", 64'(data_o), 64'(exp_q.pop_front()));
            end else begin
                chk("data_o_stall", 64'(data_o), 64'(exp_q[0]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        for (int k = 0; k < NC; k++) cnt_a[k] = {$urandom, $urandom};
    endtask

    task automatic run_until_idle(input int limit, input bit rnd_rdy, input bit scr);
        int n;
        n = 0;
        do begin
            if (rnd_rdy) ready_and_i = ($urandom_range(0, 99) < 30);
            if (scr) scramble();
            cyc();
            n++;
        end while (((m_rem != 0) || m_done) && n < limit);
        if ((m_rem != 0) || m_done) begin
            vec++;
            err++;
            $display("FAIL dump_timeout: still busy after %0d cycles, required idle", n);
        end
        ready_and_i = 1'b1;
    endtask

    task automatic request(input bit clr);
        snapshot_v_i  = 1'b1;
        clear_after_i = clr;
        cyc();
        snapshot_v_i  = 1'b0;
        clear_after_i = 1'b0;
    endtask

    initial begin
        int base, n;
        for (int k = 0; k < NC; k++) cnt_a[k] = 64'(k) * 64'h1_0000_0001;
        repeat (3) @(posedge clk);
        #1;
        started = 1;
        reset_i = 1'b0;
        cyc();

        // ramp pattern, ready held high, clear requested
        mhartid_i = 8'd3;
        request(1'b1);
        run_until_idle(200, 1'b0, 1'b0);
        cyc();

        // random data, 30% ready, no clear
        scramble();
        mhartid_i = 8'($urandom);
        request(1'b0);
        run_until_idle(1000, 1'b1, 1'b0);
        cyc();

        // counters change every cycle during the dump
        scramble();
        request(1'b1);
        run_until_idle(1000, 1'b1, 1'b1);
        cyc();

        // snapshot held high: one dump per idle entry
        scramble();
        snapshot_v_i = 1'b1;
        base = m_accepts;
        n = 0;
        while (m_accepts < base + 3 && n < 500) begin
            cyc();
            n++;
        end
        snapshot_v_i = 1'b0;
        chk("held_high_accepts", 64'(m_accepts - base), 64'd3);
        run_until_idle(200, 1'b0, 1'b0);
        cyc();

        // reset after 10 transfers abandons the dump
        scramble();
        request(1'b1);
        repeat (10) cyc();
        reset_i = 1'b1;
        cyc();
        reset_i = 1'b0;
        repeat (3) cyc();

        // restart after the abandoned dump
        scramble();
        request(1'b1);
        run_until_idle(1000, 1'b1, 1'b0);
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
